// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and the pwm_capture decoder.
// The master drives pwm_in; the slave (the decoder) drives the capture results.
interface pwm_capture_if #(
  parameter int CNT_W = 8
);
  logic               pwm_in;
  logic [2*CNT_W-1:0] capture_reg;
  logic               valid;
  logic               stuck_high;
  logic               stuck_low;

  modport master (
    output pwm_in,
    input  capture_reg,
    input  valid,
    input  stuck_high,
    input  stuck_low
  );

  modport slave (
    input  pwm_in,
    output capture_reg,
    output valid,
    output stuck_high,
    output stuck_low
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, re-encodes them as
// {period-1, high-1} in generator register format, and flags stuck-high/stuck-low inputs.
module pwm_capture #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  pwm_capture_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W:0]   P_ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   P_MAX = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]   P_ARM = (CNT_W+1)'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] F_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;
  logic                   s_s;
  logic                   rise_s;
  logic                   fall_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W:0]         p_r;
  logic [CNT_W:0]         h_r;
  logic [CNT_W:0]         p_nxt_s;
  logic [CNT_W:0]         h_nxt_s;
  logic [CNT_W:0]         p_inc_s;
  logic                   near_max_s;
  logic [CNT_W-1:0]       p_pub_s;
  logic [CNT_W-1:0]       h_pub_s;
  logic                   publish_s;
  logic                   set_high_s;
  logic                   set_low_s;
  logic [2*CNT_W-1:0]     capture_r;
  logic                   valid_r;
  logic                   stuck_high_r;
  logic                   stuck_low_r;

  assign s_s        = sync_r[SYNC_STAGES-1];
  assign rise_s     = s_s & ~s_d_r;
  assign fall_s     = ~s_s & s_d_r;
  assign p_inc_s    = (p_r == P_MAX) ? P_MAX : (p_r + P_ONE);
  assign near_max_s = (p_r == (P_MAX - P_ONE));
  // A full 2^CNT_W count wraps to all-ones in the low bits, which is the intended encoding.
  assign p_pub_s    = p_r[CNT_W-1:0] - F_ONE;
  assign h_pub_s    = h_r[CNT_W-1:0] - F_ONE;

  // Input synchronizer and one-cycle delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.pwm_in};
      s_d_r  <= s_s;
    end
  end

  // FSM state and measurement counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      p_r     <= {(CNT_W+1){1'b0}};
      h_r     <= {(CNT_W+1){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      p_r     <= p_nxt_s;
      h_r     <= h_nxt_s;
    end
  end

  // Next-state, counter update and publish/timeout decisions
  always_comb begin
    state_nxt_s = state_r;
    p_nxt_s     = p_r;
    h_nxt_s     = h_r;
    publish_s   = 1'b0;
    set_high_s  = 1'b0;
    set_low_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Wait for the synchronizer to settle low so its reset value cannot fake a rise.
        p_nxt_s     = p_inc_s;
        set_high_s  = near_max_s & s_s;
        set_low_s   = near_max_s & ~s_s;
        state_nxt_s = ((p_r >= P_ARM) && !s_s) ? ST_ARMED : ST_IDLE;
      end
      ST_ARMED: begin
        if (rise_s) begin
          p_nxt_s     = P_ONE;
          h_nxt_s     = P_ONE;
          state_nxt_s = ST_HIGH;
        end else begin
          p_nxt_s    = p_inc_s;
          set_high_s = near_max_s & s_s;
          set_low_s  = near_max_s & ~s_s;
        end
      end
      ST_HIGH: begin
        if (p_r == P_MAX) begin
          set_high_s  = 1'b1;
          p_nxt_s     = {(CNT_W+1){1'b0}};
          state_nxt_s = ST_IDLE;
        end else if (fall_s) begin
          p_nxt_s     = p_r + P_ONE;
          state_nxt_s = ST_LOW;
        end else begin
          p_nxt_s = p_r + P_ONE;
          h_nxt_s = h_r + P_ONE;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          publish_s   = 1'b1;
          p_nxt_s     = P_ONE;
          h_nxt_s     = P_ONE;
          state_nxt_s = ST_HIGH;
        end else if (p_r == P_MAX) begin
          set_low_s   = 1'b1;
          p_nxt_s     = {(CNT_W+1){1'b0}};
          state_nxt_s = ST_IDLE;
        end else begin
          p_nxt_s = p_r + P_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        p_nxt_s     = {(CNT_W+1){1'b0}};
        h_nxt_s     = {(CNT_W+1){1'b0}};
      end
    endcase
  end

  // Registered capture value, valid pulse and sticky stuck flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_r    <= {(2*CNT_W){1'b0}};
      valid_r      <= 1'b0;
      stuck_high_r <= 1'b0;
      stuck_low_r  <= 1'b0;
    end else begin
      capture_r    <= publish_s ? {p_pub_s, h_pub_s} : capture_r;
      valid_r      <= publish_s;
      stuck_high_r <= publish_s ? 1'b0 : (stuck_high_r | set_high_s);
      stuck_low_r  <= publish_s ? 1'b0 : (stuck_low_r | set_low_s);
    end
  end

  assign bus.capture_reg = capture_r;
  assign bus.valid       = valid_r;
  assign bus.stuck_high  = stuck_high_r;
  assign bus.stuck_low   = stuck_low_r;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed and random PWM waveforms checked
// against a rise-to-rise timing model of the expected captures.
module tb_pwm_capture;
  localparam int CNT_W = 8;
  localparam int S     = 2;
  localparam int PMAX  = 256;

  typedef struct {
    int          at;
    logic [15:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  pwm_capture_if #(.CNT_W(CNT_W)) bus();

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          cyc       = 0;
  ev_t         expq[$];
  logic [15:0] last_cap  = 16'h0000;
  int          prev_rise = 0;
  bit          have_prev = 1'b0;
  int          cur_high  = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: sample outputs after the edge and compare with the capture model.
  task automatic tick();
    bit ev;
    @(posedge clk);
    #1;
    cyc++;
    ev = (expq.size() > 0) && (expq[0].at == cyc);
    check("valid", 32'(bus.valid), 32'(ev));
    while ((expq.size() > 0) && (expq[0].at <= cyc)) begin
      last_cap = expq[0].val;
      void'(expq.pop_front());
    end
    check("capture_reg", 32'(bus.capture_reg), 32'(last_cap));
  endtask

  // Input goes high now; it is sampled at the next edge and seen as a rise S edges later.
  // Two rises at most 2^CNT_W cycles apart publish the period between them.
  task automatic note_rise();
    int   proc;
    ev_t  e;
    proc = cyc + 1 + S;
    if (have_prev && ((proc - prev_rise) <= PMAX)) begin
      e.at  = proc;
      e.val = {8'(proc - prev_rise - 1), 8'(cur_high - 1)};
      expq.push_back(e);
    end
    prev_rise = proc;
    have_prev = 1'b1;
  endtask

  task automatic run_period(input int hi, input int lo);
    bus.pwm_in = 1'b1;
    note_rise();
    repeat (hi) tick();
    bus.pwm_in = 1'b0;
    cur_high   = hi;
    repeat (lo) tick();
  endtask

  task automatic hold_low(input int n);
    bus.pwm_in = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int p;
    int h;
    bus.pwm_in = 1'b0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset capture_reg", 32'(bus.capture_reg), 32'h0);
    check("reset valid", 32'(bus.valid), 32'h0);
    check("reset stuck_high", 32'(bus.stuck_high), 32'h0);
    check("reset stuck_low", 32'(bus.stuck_low), 32'h0);
    reset = 1'b0;
    cyc   = 0;

    // Held low from reset: stuck_low once the period counter reaches 2^CNT_W.
    repeat (255) tick();
    check("stuck_low before 256", 32'(bus.stuck_low), 32'h0);
    tick();
    check("stuck_low at 256", 32'(bus.stuck_low), 32'h1);
    check("stuck_high idle low", 32'(bus.stuck_high), 32'h0);
    repeat (10) tick();

    // Generator 0x0400, then 0x0903, 0xFF7F, minimum period, and period 256.
    repeat (4) run_period(1, 4);
    check("stuck_low cleared by valid", 32'(bus.stuck_low), 32'h0);
    repeat (4) run_period(4, 6);
    repeat (3) run_period(128, 128);
    repeat (3) run_period(1, 1);
    repeat (2) run_period(255, 1);

    // Random legal periods 2..256.
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(PMAX, 2));
      h = int'($urandom_range(p - 1, 1));
      run_period(h, p - h);
    end
    check("random stuck_high", 32'(bus.stuck_high), 32'h0);
    check("random stuck_low", 32'(bus.stuck_low), 32'h0);

    // Constant high (duty >= count): stuck_high within the timeout bound, no stuck_low.
    bus.pwm_in = 1'b1;
    note_rise();
    repeat (PMAX + S + 4) tick();
    check("stuck_high const high", 32'(bus.stuck_high), 32'h1);
    check("stuck_low const high", 32'(bus.stuck_low), 32'h0);
    repeat (40) tick();
    hold_low(20);
    repeat (3) run_period(4, 6);
    check("stuck_high cleared", 32'(bus.stuck_high), 32'h0);

    // Period 300 is too long: stuck_low, no publish; then period 50 / high 20.
    repeat (3) run_period(100, 200);
    check("stuck_low period 300", 32'(bus.stuck_low), 32'h1);
    check("stuck_high period 300", 32'(bus.stuck_high), 32'h0);
    repeat (3) run_period(20, 30);
    check("capture 0x3113", 32'(bus.capture_reg), 32'h3113);
    check("stuck_low after 0x3113", 32'(bus.stuck_low), 32'h0);

    // Reset in the middle of a high phase.
    bus.pwm_in = 1'b1;
    note_rise();
    repeat (10) tick();
    #3;
    reset = 1'b1;
    #1;
    check("midreset capture_reg", 32'(bus.capture_reg), 32'h0);
    check("midreset valid", 32'(bus.valid), 32'h0);
    check("midreset stuck_high", 32'(bus.stuck_high), 32'h0);
    check("midreset stuck_low", 32'(bus.stuck_low), 32'h0);
    expq.delete();
    have_prev  = 1'b0;
    last_cap   = 16'h0000;
    bus.pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hold_low(10);
    repeat (3) run_period(20, 30);
    hold_low(5);
    check("post-reset capture", 32'(bus.capture_reg), 32'h3113);
    check("pending captures", 32'(expq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
